// File: rtl/score_hud_renderer.sv
// score_hud_renderer
//   Score/miss HUD stage. Keeps a 3-digit BCD score and a saturating miss
//   counter. Maps the raster position onto digit and miss-icon cells, drives
//   the Numbers and Miss sprite ROM addresses, and aligns the ROM data into
//   one HUD pixel two cycles after the raster position was presented.
//
//   Ports:
//     clock, resetn            system clock, async active-low reset
//     score_inc, miss_inc      1-cycle increment pulses
//     game_clear               sync clear of score and misses (wins over incs)
//     pix_x, pix_y, pix_valid  raster position and qualifier
//     num_addr / num_q         Numbers ROM address (comb) / data (1 cycle later)
//     miss_addr / miss_q       Miss ROM address (comb) / data (1 cycle later)
//     hud_pixel, hud_valid     HUD ink and qualifier, 2 cycles after pix
//     score_bcd                {hundreds, tens, ones}
//     miss_count, game_over    misses so far, high while misses == MAX_MISS
//
//   Build option: define HUD_LZ_BLANK_EN to blank leading-zero score digits.
module score_hud_renderer #(
  parameter logic [9:0] SCORE_X     = 10'd240,
  parameter logic [8:0] SCORE_Y     = 9'd8,
  parameter logic [3:0] DIGIT_PITCH = 4'd8,
  parameter logic [9:0] MISS_X      = 10'd16,
  parameter logic [8:0] MISS_Y      = 9'd4,
  parameter logic [5:0] MISS_PITCH  = 6'd32,
  parameter logic [1:0] MAX_MISS    = 2'd3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        score_inc,
  input  logic        miss_inc,
  input  logic        game_clear,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  input  logic        pix_valid,
  output logic [9:0]  num_addr,
  input  logic        num_q,
  output logic [9:0]  miss_addr,
  input  logic        miss_q,
  output logic        hud_pixel,
  output logic        hud_valid,
  output logic [11:0] score_bcd,
  output logic [1:0]  miss_count,
  output logic        game_over
);

  localparam logic [9:0] DP10   = {6'b0, DIGIT_PITCH};
  localparam logic [9:0] MP10   = {4'b0, MISS_PITCH};
  localparam logic [9:0] SX_END = SCORE_X + 10'd3 * DP10;
  localparam logic [9:0] SY_LO  = {1'b0, SCORE_Y};
  localparam logic [9:0] SY_HI  = {1'b0, SCORE_Y} + 10'd7;
  localparam logic [9:0] MY_LO  = {1'b0, MISS_Y};
  localparam logic [9:0] MY_HI  = {1'b0, MISS_Y} + 10'd27;

  logic [11:0] score_q, score_d;
  logic [1:0]  miss_q_cnt, miss_d_cnt;
  logic        game_over_q, game_over_d;
  logic        num_hit1_q, miss_hit1_q, valid1_q;
  logic        hud_pixel_q, hud_valid_q;

  // ---------------- score / miss bookkeeping ----------------
  always_comb begin
    score_d = score_q;
    if (game_clear) begin
      score_d = '0;
    end else if (score_inc) begin
      // BCD ripple: each digit wraps 9->0 and carries into the next
      if (score_q[3:0] == 4'd9) begin
        score_d[3:0] = '0;
        if (score_q[7:4] == 4'd9) begin
          score_d[7:4]  = '0;
          score_d[11:8] = (score_q[11:8] == 4'd9) ? 4'd0 : score_q[11:8] + 4'd1;
        end else begin
          score_d[7:4] = score_q[7:4] + 4'd1;
        end
      end else begin
        score_d[3:0] = score_q[3:0] + 4'd1;
      end
    end
  end

  always_comb begin
    miss_d_cnt = miss_q_cnt;
    if (game_clear)
      miss_d_cnt = '0;
    else if (miss_inc && (miss_q_cnt != MAX_MISS))
      miss_d_cnt = miss_q_cnt + 2'd1;
    game_over_d = (miss_d_cnt == MAX_MISS);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      score_q     <= '0;
      miss_q_cnt  <= '0;
      game_over_q <= 1'b0;
    end else begin
      score_q     <= score_d;
      miss_q_cnt  <= miss_d_cnt;
      game_over_q <= game_over_d;
    end
  end

  // ---------------- stage 0: cell mapping and ROM addressing ----------------
  logic [9:0] py10, sx_off, sy_off, s_k, s_col, mx_off, my_off, m_j, m_col;
  logic [3:0] digit;
  logic       s_in, m_in, blank, num_hit, miss_hit;

  always_comb begin
    py10   = {1'b0, pix_y};
    sx_off = pix_x - SCORE_X;
    sy_off = py10 - SY_LO;
    s_k    = sx_off / DP10;
    s_col  = sx_off - s_k * DP10;
    s_in   = pix_valid && (pix_x >= SCORE_X) && (pix_x < SX_END) &&
             (py10 >= SY_LO) && (py10 <= SY_HI);

    case (s_k)
      10'd0:   digit = score_q[11:8];
      10'd1:   digit = score_q[7:4];
      default: digit = score_q[3:0];
    endcase

`ifdef HUD_LZ_BLANK_EN
    blank = ((s_k == 10'd0) && (score_q[11:8] == 4'd0)) ||
            ((s_k == 10'd1) && (score_q[11:4] == 8'd0));
`else
    blank = 1'b0;
`endif

    num_hit  = s_in && (s_col < 10'd7) && !blank;
    num_addr = num_hit ? ({6'b0, digit} * 10'd56 + sy_off * 10'd7 + s_col) : '0;

    mx_off = pix_x - MISS_X;
    my_off = py10 - MY_LO;
    m_j    = mx_off / MP10;
    m_col  = mx_off - m_j * MP10;
    m_in   = pix_valid && (pix_x >= MISS_X) && (py10 >= MY_LO) && (py10 <= MY_HI);
    // only icons below the current miss count are drawn
    miss_hit  = m_in && (m_j < {8'b0, miss_q_cnt}) && (m_col < 10'd28);
    miss_addr = miss_hit ? (my_off * 10'd28 + m_col) : '0;
  end

  // ---------------- stages 1 and 2 ----------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      num_hit1_q  <= 1'b0;
      miss_hit1_q <= 1'b0;
      valid1_q    <= 1'b0;
      hud_pixel_q <= 1'b0;
      hud_valid_q <= 1'b0;
    end else begin
      num_hit1_q  <= num_hit;
      miss_hit1_q <= miss_hit;
      valid1_q    <= pix_valid;
      // ROM data arrives alongside the stage-1 hit flags
      hud_pixel_q <= valid1_q & ((num_hit1_q & num_q) | (miss_hit1_q & miss_q));
      hud_valid_q <= valid1_q;
    end
  end

  assign hud_pixel  = hud_pixel_q;
  assign hud_valid  = hud_valid_q;
  assign score_bcd  = score_q;
  assign miss_count = miss_q_cnt;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_score_hud_renderer.sv
module tb_score_hud_renderer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        score_inc = 1'b0, miss_inc = 1'b0, game_clear = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [8:0]  pix_y = '0;
  logic        pix_valid = 1'b0;
  logic [9:0]  num_addr, miss_addr;
  logic        num_q = 1'b0, miss_q = 1'b0;
  logic        hud_pixel, hud_valid, game_over;
  logic [11:0] score_bcd;
  logic [1:0]  miss_count;

  score_hud_renderer dut (
    .clock(clock), .resetn(resetn),
    .score_inc(score_inc), .miss_inc(miss_inc), .game_clear(game_clear),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .num_addr(num_addr), .num_q(num_q),
    .miss_addr(miss_addr), .miss_q(miss_q),
    .hud_pixel(hud_pixel), .hud_valid(hud_valid),
    .score_bcd(score_bcd), .miss_count(miss_count), .game_over(game_over)
  );

  always #5 clock = ~clock;

  // Sprite ROM stand-ins: synchronous read, one cycle latency
  bit num_rom[1024];
  bit miss_rom[1024];
  always @(posedge clock) begin
    num_q  <= num_rom[num_addr];
    miss_q <= miss_rom[miss_addr];
  end

  // Reference state
  int m_score, m_miss;
  bit p1, p2, pv1, pv2;
  int last_naddr, last_maddr;
  int n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int s);
    return (s / 100) * 256 + ((s / 10) % 10) * 16 + (s % 10);
  endfunction

  task automatic model_pix(input int x, input int y, input bit v,
                           output bit nhit, output int naddr,
                           output bit mhit, output int maddr);
    int k, col, d, h, t, j;
    bit blank;
    nhit = 0; naddr = 0; mhit = 0; maddr = 0;
    h = m_score / 100;
    t = (m_score / 10) % 10;
    if (v && y >= 8 && y <= 15 && x >= 240 && x < 264) begin
      k   = (x - 240) / 8;
      col = (x - 240) % 8;
      d   = (k == 0) ? h : (k == 1) ? t : m_score % 10;
      blank = 0;
`ifdef HUD_LZ_BLANK_EN
      blank = (k == 0 && h == 0) || (k == 1 && h == 0 && t == 0);
`endif
      if (col < 7 && !blank) begin
        nhit  = 1;
        naddr = d * 56 + (y - 8) * 7 + col;
      end
    end
    if (v && y >= 4 && y <= 31 && x >= 16) begin
      j   = (x - 16) / 32;
      col = (x - 16) % 32;
      if (j < m_miss && col < 28) begin
        mhit  = 1;
        maddr = (y - 4) * 28 + col;
      end
    end
  endtask

  // One clock: drive, check mid-cycle, advance the model, step to posedge+1
  task automatic cyc(input bit si, input bit mi, input bit gc,
                     input int x, input int y, input bit v);
    bit nhit, mhit, ep;
    int naddr, maddr;
    score_inc = si; miss_inc = mi; game_clear = gc;
    pix_x = 10'(x); pix_y = 9'(y); pix_valid = v;
    #4;
    model_pix(x, y, v, nhit, naddr, mhit, maddr);
    last_naddr = int'(num_addr);
    last_maddr = int'(miss_addr);
    chk("num_addr",   num_addr,   naddr);
    chk("miss_addr",  miss_addr,  maddr);
    chk("hud_pixel",  hud_pixel,  p2);
    chk("hud_valid",  hud_valid,  pv2);
    chk("score_bcd",  score_bcd,  to_bcd(m_score));
    chk("miss_count", miss_count, m_miss);
    chk("game_over",  game_over,  m_miss == 3);
    ep  = v & ((nhit & num_rom[naddr]) | (mhit & miss_rom[maddr]));
    p2  = p1;  pv2 = pv1;
    p1  = ep;  pv1 = v;
    if (gc) begin
      m_score = 0; m_miss = 0;
    end else begin
      if (si) m_score = (m_score + 1) % 1000;
      if (mi && m_miss < 3) m_miss++;
    end
    @(posedge clock); #1;
  endtask

  task automatic mid_reset(input int x, input int y);
    score_inc = 0; miss_inc = 0; game_clear = 0;
    pix_x = 10'(x); pix_y = 9'(y); pix_valid = 1;
    resetn = 0;
    #4;
    chk("rst_hud_valid", hud_valid, 0);
    chk("rst_hud_pixel", hud_pixel, 0);
    chk("rst_score",     score_bcd, 0);
    chk("rst_miss",      miss_count, 0);
    chk("rst_game_over", game_over, 0);
    m_score = 0; m_miss = 0;
    p1 = 0; p2 = 0; pv1 = 0; pv2 = 0;
    @(posedge clock); #1;
    resetn = 1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_score = 0; m_miss = 0;
    for (int i = 0; i < 1024; i++) begin
      num_rom[i]  = 1'($urandom_range(0, 1));
      miss_rom[i] = 1'($urandom_range(0, 1));
    end

    // reset state
    #3;
    chk("init_hud_pixel", hud_pixel, 0);
    chk("init_hud_valid", hud_valid, 0);
    chk("init_score",     score_bcd, 0);
    chk("init_miss",      miss_count, 0);
    chk("init_game_over", game_over, 0);
    @(posedge clock); #1;
    resetn = 1;

    // score: 12 then wrap after 1000
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0, 1);
    chk("t1_score_012", score_bcd, 12'h012);
    for (int i = 0; i < 988; i++) cyc(1, 0, 0, 0, 0, 1);
    chk("t1_score_wrap", score_bcd, 12'h000);

    // misses saturate, game_over, clear priority
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      chk("t2_miss", miss_count, (i < 3) ? i + 1 : 3);
      chk("t2_game_over", game_over, i >= 2);
    end
    cyc(0, 1, 1, 0, 0, 0);
    chk("t2_clear_miss", miss_count, 0);
    chk("t2_clear_go",   game_over, 0);

    // digit addressing at score 307
    for (int i = 0; i < 307; i++) cyc(1, 0, 0, 0, 0, 0);
    num_rom[37] = 1;
    cyc(0, 0, 0, 240 + 8 + 2, 8 + 5, 1);
    chk("t3_num_addr", last_naddr, 37);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t3_hud_pixel", hud_pixel, 1);
    chk("t3_hud_valid", hud_valid, 1);

    // miss icon corner and out-of-count icon
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    miss_rom[783] = 1;
    miss_rom[0]   = 1;
    cyc(0, 0, 0, 16 + 32 + 27, 4 + 27, 1);
    chk("t4_miss_addr", last_maddr, 783);
    cyc(0, 0, 0, 16 + 64, 4, 1);
    chk("t4_hit_pixel", hud_pixel, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t4_nohit_pixel", hud_pixel, 0);
    chk("t4_nohit_valid", hud_valid, 1);

    // leading-zero behaviour on the hundreds cell at score 005
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0);
    num_rom[0] = 1;
    cyc(0, 0, 0, 240, 8, 1);
    cyc(0, 0, 0, 0, 0, 0);
`ifdef HUD_LZ_BLANK_EN
    chk("t5_lz_pixel", hud_pixel, 0);
`else
    chk("t5_lz_pixel", hud_pixel, 1);
`endif

    // randomized traffic with periodic mid-stream resets
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350)
        mid_reset(int'($urandom_range(230, 270)), int'($urandom_range(0, 20)));
      else
        cyc($urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0,
            $urandom_range(0, 150) == 0,
            int'($urandom_range(0, 300)), int'($urandom_range(0, 40)),
            $urandom_range(0, 7) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
